axi_write_responder: RTL
========================

// Module: axi_write_responder
//
// PURPOSE
//  Write-side SAXI slave: the responder end of the master's run_write/start_write traffic.
//  Accepts AW and W transfers independently, in any relative order (addr-first, data-first,
//  back-to-back), queues each, pairs them in order, stores the data, returns one B response.
//  Sits beside the read-side slave on the shared SAXI signal set.
//
// PARAMETERS
//  FIFO_DEPTH  4  entries in each of the AW and W queues (power of 2, >= 2)
//  MEM_WORDS   16 words of internal storage (power of 2)
//  ADDR_LSB    8  lowest awaddr bit of the word index: idx = awaddr[ADDR_LSB +: $clog2(MEM_WORDS)]
//  RESP_DELAY  2  idle cycles between pairing and bvalid (0 allowed)
//
// PORTS
//  clk      in   1        clock, all logic on posedge
//  rst      in   1        synchronous, active-high reset
//  awaddr   in   addr_t   write address
//  awvalid  in   1        write address valid
//  awready  out  1        write address ready
//  wdata    in   data_t   write data
//  wvalid   in   1        write data valid
//  wready   out  1        write data ready
//  bvalid   out  1        write response valid
//  bready   in   1        write response ready
//  dbg_addr in   addr_t   debug read address, same index mapping as awaddr
//  dbg_data out  data_t   mem[dbg_addr index], combinational
//
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - While rst = 1: awready = 0, wready = 0, bvalid = 0.
//   - At the rst edge: both queues flushed, FSM -> IDLE.
//   - Memory is not cleared.
//   - Reset mid-operation: a pending B and all queued AW/W are discarded; bvalid is low
//     from the cycle after the rst edge.
//  Accept:
//   - awready = !rst && !aw_full; wready = !rst && !w_full. No combinational valid->ready path.
//   - Push on valid && ready. Push and pop in the same cycle are legal when not full.
//   - A full queue accepts only after a pop has registered; there is no pass-through.
//  Pairing: at an edge where FSM == IDLE and both queues are non-empty:
//   - Pop the AW head and the W head together.
//   - mem[idx(aw)] <= w.
//   - If RESP_DELAY == 0, FSM -> RESP; otherwise FSM -> WAIT with cnt = RESP_DELAY - 1.
//  FSM:
//   - IDLE: pairing as above.
//   - WAIT: when cnt == 0, -> RESP; otherwise cnt decrements.
//   - RESP: bvalid = 1, held stable until bready. At the bvalid && bready edge -> IDLE.
//     The next pairing takes place no earlier than the following edge.
//  Latency:
//   - Let E be the later of the AW and W handshake edges.
//   - Pairing happens at E+1 when the FSM is idle.
//   - bvalid is high starting the cycle after edge E+1+RESP_DELAY.
//  Ordering and capacity:
//   - B responses are strictly in AW/W arrival order. One write is in flight past pairing.
//   - Up to 2*FIFO_DEPTH transfers (AW + W) are queued behind it.
//  Boundary cases:
//   - W with no AW (or AW with no W) waits in its queue indefinitely; no timeout.
//   - A write to an index and a dbg read of the same index in the same cycle: dbg_data
//     shows the old value, the new value from the next cycle.
//   - Address bits outside the index field are ignored (aliasing is permitted).
//
// STRUCTURE
//  - Package axi_transaction: addr_t, data_t (already shared with master/slave).
//  - Local enum state_t {IDLE, WAIT, RESP}; local delay counter of width $clog2(RESP_DELAY+1).
//  - Sub-module axi_sync_fifo #(type T, DEPTH): registered full/empty, synchronous
//    active-high rst. Instantiated twice: addr_t for AW, data_t for W.
//
// TESTING (RESP_DELAY = 2, bready = 1 unless stated)
//  1. Single write 'h100/'h123, AW+W same edge E -> bvalid high after edge E+3 for one cycle;
//     dbg_addr 'h100 -> 'h123.
//  2. Three back-to-back start_write 'h400/'h11, 'h500/'h22, 'h600/'h33 -> awready/wready stay 1;
//     exactly 3 bvalid pulses; mem idx 4/5/6 = 'h11/'h22/'h33.
//  3. Data delayed 3 cycles ('h700/'h123) -> AW accepted at E0; no bvalid before W handshake E0+3;
//     bvalid after edge E0+3+3.
//  4. Addr delayed 3 cycles ('ha00/'h456) -> symmetric to test 3; mem idx 10 = 'h456.
//  5. bready = 0, six writes issued -> awready/wready drop once 4 entries are queued
//     (1 in RESP + 4 queued); bready = 1 -> six in-order B handshakes, all six data values stored.
//  6. rst pulsed while bvalid = 1 and 2 writes queued -> bvalid 0 after the rst edge;
//     no further B responses; awready/wready 1 after rst falls; the next write completes normally.

Source files
------------

// File: rtl/axi_write_responder_pkg.sv
// ============================================================================
// axi_transaction : address/data types shared by the SAXI master and slaves
// Revision 1.0
// ============================================================================
`default_nettype none

package axi_transaction;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/axi_write_responder_fifo.sv
// ============================================================================
// axi_sync_fifo : synchronous FIFO with registered full/empty flags
// Revision 1.0
// ============================================================================
`default_nettype none

module axi_sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  // Push is gated on the registered full flag, so a full queue never passes data through.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PTR_W+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/axi_write_responder.sv
// ============================================================================
// axi_write_responder : SAXI write slave - queues AW and W, pairs them in
// order, stores data, returns one B response per write
// Revision 1.0
// ============================================================================
`default_nettype none

module axi_write_responder
  import axi_transaction::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 16,
  parameter int ADDR_LSB   = 8,
  parameter int RESP_DELAY = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  addr_t awaddr,
  input  logic  awvalid,
  output logic  awready,
  input  data_t wdata,
  input  logic  wvalid,
  output logic  wready,
  output logic  bvalid,
  input  logic  bready,
  input  addr_t dbg_addr,
  output data_t dbg_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pair;
  logic             aw_full, aw_empty, w_full, w_empty;
  addr_t            aw_head;
  data_t            w_head;
  data_t            mem [MEM_WORDS];
  logic             unused_addr_bits;

  assign awready = !rst && !aw_full;
  assign wready  = !rst && !w_full;
  assign bvalid  = !rst && (state == RESP);

  axi_sync_fifo #(.T(addr_t), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (awvalid && awready),
    .push_data (awaddr),
    .pop       (pair),
    .pop_data  (aw_head),
    .full      (aw_full),
    .empty     (aw_empty)
  );

  axi_sync_fifo #(.T(data_t), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wvalid && wready),
    .push_data (wdata),
    .pop       (pair),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pair       = 1'b0;
    case (state)
      IDLE: begin
        if (!aw_empty && !w_empty) begin
          pair = 1'b1;
          if (RESP_DELAY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      RESP: begin
        if (bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (pair && !rst) mem[aw_head[ADDR_LSB +: IDX_W]] <= w_head;
  end

  assign dbg_data         = mem[dbg_addr[ADDR_LSB +: IDX_W]];
  assign unused_addr_bits = ^{aw_head, dbg_addr};

endmodule

`default_nettype wire
